addsub_result_stage: RTL
========================

Name: addsub_result_stage

Overview:
- Registered result stage directly downstream of the 4-bit adder/subtractor (addsub). It takes the operands, the mode bit M, the sum S and the carry C from that unit.
- It computes status flags Z, N, V and C, and buffers each result in a 2-entry skid FIFO with a valid/ready handshake toward the consumer.
- It also keeps a sticky overflow flag and a count of retired operations.
- It decouples the combinational addsub from downstream backpressure. in_ready never depends combinationally on out_ready.

Parameters:
- WIDTH, 4: operand and result width. Must match addsub.
- CNT_W, 8: width of the op_count counter.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Upstream result present.
- in_ready  out  1  Stage can accept this cycle.
- in_a  in  WIDTH  Operand A as presented to addsub.
- in_b  in  WIDTH  Operand B as presented to addsub.
- in_m  in  1  Mode: 0 = add, 1 = subtract.
- in_s  in  WIDTH  Sum/difference from addsub.
- in_c  in  1  Carry-out from addsub.
- out_valid  out  1  Head entry valid.
- out_ready  in  1  Consumer accepts head.
- out_s  out  WIDTH  Head result.
- out_m  out  1  Head mode.
- out_flags  out  4  Head flags {Z,N,V,C}, bit3..bit0.
- sticky_v  out  1  Set once any accepted op overflowed.
- sticky_clr  in  1  Synchronous clear of sticky_v.
- op_count  out  CNT_W  Number of popped entries, modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, out_s=0, out_m=0, out_flags=0, sticky_v=0, op_count=0. in_ready=1 from the first edge after release. A reset mid-transfer discards all buffered entries.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (occupancy != 2). It is a function of registered state only.
- out_valid = (occupancy != 0).
- Latency: an entry pushed at edge N into an empty FIFO is visible on the outputs after edge N (out_valid=1 during cycle N+1).
- Ordering is strict FIFO.
- Push and pop in the same cycle:
  - Occupancy unchanged.
  - At occupancy 1, the new entry becomes head on the next cycle.
  - At occupancy 2 no push can occur, because in_ready=0.
- Output data registers hold their last value when out_valid=0. Consumers must ignore them.
- Flags are computed at push from the in_* signals (msb = WIDTH-1):
  - Z = (in_s == 0)
  - N = in_s[msb]
  - C = in_c, the raw carry-out. For subtract, C=1 means no borrow.
  - V for add (in_m=0): (in_a[msb] == in_b[msb]) && (in_s[msb] != in_a[msb])
  - V for subtract (in_m=1): (in_a[msb] != in_b[msb]) && (in_s[msb] != in_a[msb])
- sticky_v is set on a push whose V=1 and cleared by sticky_clr. If both happen in the same cycle, set wins.
- op_count increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
- in_s and in_c are not re-checked against in_a/in_b. They are captured as given.

Decomposition:
- Package alu_pkg:
  - WIDTH default.
  - Flag bit index constants FLG_Z=3, FLG_N=2, FLG_V=1, FLG_C=0.
  - Mode constants MODE_ADD=0, MODE_SUB=1.
  - Packed entry typedef {s, m, flags}.
- One sub-module: addsub_flag_calc, purely combinational (a, b, m, s, c -> flags[3:0]). It is reused by future ALU stages.
- FIFO storage and pointers stay inline.

Test Plan:
- A=0000, B=1010, M=0, S=1010, C=0, out_ready=1 -> one cycle later out_valid=1, out_s=1010, flags Z=0 N=1 V=0 C=0. Then op_count=1.
- A=0011, B=0100, M=1, S=1111, C=0 -> out_s=1111, flags Z=0 N=1 V=0 C=0, sticky_v=0.
- A=0111, B=0001, M=0, S=1000, C=0 -> V=1, N=1. sticky_v=1 next cycle. Assert sticky_clr with a simultaneous V=1 push -> sticky_v stays 1. Clear alone -> 0.
- Backpressure:
  - Stimulus: out_ready=0, three back-to-back valid pushes (S=0001, 0010, 0011).
  - Response: in_ready drops to 0 after the 2nd push and the 3rd is held.
  - Then raise out_ready: outputs appear in order 0001, 0010, 0011 with no loss or duplication.
- Simultaneous push and pop at occupancy 1 over 10 consecutive cycles -> occupancy stays 1, out_valid is continuous, and op_count advances by 10.
- CNT_W=2: 5 pops -> op_count=1 (wrap).
- Reset pulse with 2 entries buffered -> out_valid=0, op_count=0, sticky_v=0 immediately (async), and in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default width, flag bit positions, mode encoding,
// the buffered result entry and the result-stage occupancy states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_C = 0;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] s;
        logic                 m;
        logic [3:0]           flags;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational status flags {Z,N,V,C} for an add/subtract result.
module addsub_flag_calc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             m_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             c_i,
    output logic [3:0]       flags_o
);

    logic same_sign;

    always_comb begin
        same_sign = (a_i[WIDTH-1] == b_i[WIDTH-1]);
        flags_o        = '0;
        flags_o[FLG_Z] = (s_i == '0);
        flags_o[FLG_N] = s_i[WIDTH-1];
        flags_o[FLG_C] = c_i;
        // Subtract overflows when operand signs differ; add when they match.
        flags_o[FLG_V] = ((m_i == MODE_SUB) ? !same_sign : same_sign)
                         && (s_i[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered result stage after addsub: flag generation, 2-entry skid FIFO,
// sticky overflow and retired-op counter. WIDTH must equal alu_pkg::ALU_WIDTH.
module addsub_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_m,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_m,
    output logic [3:0]       out_flags,
    output logic             sticky_v,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    occ_e             occ_q, occ_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;

    logic [3:0] in_flags;
    entry_t     in_entry;
    logic       push, pop;

    addsub_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .a_i     (in_a),
        .b_i     (in_b),
        .m_i     (in_m),
        .s_i     (in_s),
        .c_i     (in_c),
        .flags_o (in_flags)
    );

    assign in_entry  = '{s: in_s, m: in_m, flags: in_flags};
    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = rdy_en_q && (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_s     = head_q.s;
    assign out_m     = head_q.m;
    assign out_flags = head_q.flags;
    assign sticky_v  = sticky_q;
    assign op_count  = cnt_q;

    always_comb begin
        occ_d    = occ_q;
        head_d   = head_q;
        tail_d   = tail_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        // Head register doubles as the output register, so it only changes
        // when a new entry becomes head; an emptied FIFO keeps the last value.
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = in_entry;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = in_entry;
                end else if (push) begin
                    tail_d = in_entry;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase

        if (sticky_clr)               sticky_d = 1'b0;
        if (push && in_flags[FLG_V])  sticky_d = 1'b1;

        if (pop) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule
